// File: rtl/approx_mult.sv
// rtl/approx_mult.sv - sequential approximate 16x16 multiplier (leading-one 8-bit windows, shift-add core)
// Optional build macro APP_MULT_SAT_EN: saturate Result to 16'hFFFF on overflow instead of wrapping.
module approx_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        Done,
  output logic [15:0] Result
);

  typedef enum logic [2:0] {IDLE, NORM, MULT, SCALE, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] op_a, op_b;
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [3:0]  sh_a, sh_b;
  logic [2:0]  cnt;
  logic [15:0] acc;

  logic [3:0]  sh_a_n, sh_b_n;
  logic [7:0]  win_a_n, win_b_n;
  logic [4:0]  sh_sum;
  logic [31:0] full;
  logic [15:0] result_n;

  function automatic logic [4:0] lead_index(input logic [15:0] x);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (x[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  // Operands below 256 keep their low byte unshifted, so small products stay exact.
  function automatic logic [3:0] norm_shift(input logic [15:0] x);
    logic [4:0] p;
    p = lead_index(x);
    if (x < 16'd256) return 4'd0;
    return 4'(p - 5'd7);
  endfunction

  always_comb begin
    sh_a_n  = norm_shift(op_a);
    sh_b_n  = norm_shift(op_b);
    win_a_n = 8'(op_a >> sh_a_n);
    win_b_n = 8'(op_b >> sh_b_n);
    sh_sum  = 5'(sh_a) + 5'(sh_b);
    full    = {16'h0000, acc} << sh_sum;
    if (|full[31:16]) begin
`ifdef APP_MULT_SAT_EN
      result_n = 16'hFFFF;
`else
      result_n = full[15:0];
`endif
    end else begin
      result_n = full[15:0];
    end
  end

  always_comb begin
    state_next = state;
    Done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = NORM;
      NORM:  state_next = MULT;
      MULT:  if (cnt == 3'd7) state_next = SCALE;
      SCALE: state_next = DONE;
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      mcand  <= '0;
      mplier <= '0;
      sh_a   <= '0;
      sh_b   <= '0;
      cnt    <= '0;
      acc    <= '0;
      Result <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            op_a <= A;
            op_b <= B;
          end
        end
        NORM: begin
          mcand  <= {8'h00, win_a_n};
          mplier <= win_b_n;
          sh_a   <= sh_a_n;
          sh_b   <= sh_b_n;
          acc    <= '0;
          cnt    <= '0;
        end
        MULT: begin
          // LSB-first: the multiplicand is pre-shifted so each step adds at its weight.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
        end
        SCALE: Result <= result_n;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mult.sv
// tb/tb_approx_mult.sv - directed self-checking bench for approx_mult
module tb_approx_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A, B;
  logic        Done;
  logic [15:0] Result;

  int compared   = 0;
  int mismatched = 0;
  int n;
  int pulses;

  approx_mult dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns the number of edges until Done is seen, or -1 if the budget expires.
  task automatic wait_done(input int budget, output int cnt_out);
    cnt_out = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (Done === 1'b1) begin
        cnt_out = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp);
    int lat;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(20, lat);
    check_int({tag, "_latency"}, lat, 10);
    check16({tag, "_result"}, Result, exp);
    @(posedge clk); #1;
    check16({tag, "_done_pulse"}, {15'h0, Done}, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check16("reset_done", {15'h0, Done}, 16'h0000);
      check16("reset_result", Result, 16'h0000);
      @(posedge clk); #1;
    end

    // start held 3 cycles: only the IDLE edge is accepted
    @(negedge clk);
    A = 16'h0003; B = 16'h00F0; start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(20, n);
    check_int("held_start_latency", n, 8);
    check16("held_start_result", Result, 16'h02D0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (Done === 1'b1) pulses++;
    end
    check_int("held_start_no_second", pulses, 0);

    run_op("trunc_1ff", 16'h01FF, 16'h0003, 16'h05FA);
    run_op("exact_200", 16'h0200, 16'h0005, 16'h0A00);
    run_op("small_ff", 16'h00FF, 16'h00FF, 16'hFE01);
`ifdef APP_MULT_SAT_EN
    run_op("overflow", 16'h0100, 16'h0100, 16'hFFFF);
`else
    run_op("overflow", 16'h0100, 16'h0100, 16'h0000);
`endif
    run_op("ffff_x1", 16'hFFFF, 16'h0001, 16'hFF00);
    run_op("zero_op", 16'h0000, 16'hFFFF, 16'h0000);
    run_op("pre_abort", 16'h0200, 16'h0005, 16'h0A00);

    // reset during MULT aborts with no Done and clears Result
    @(negedge clk);
    A = 16'h0003; B = 16'h0003; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check16("abort_result", Result, 16'h0000);
    check16("abort_done", {15'h0, Done}, 16'h0000);
    wait_done(15, n);
    check_int("abort_no_done", n, -1);
    run_op("after_abort", 16'h0003, 16'h0003, 16'h0009);

    // start held through DONE: back-to-back ops; late A/B change only affects the second
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    A = 16'h00FF; B = 16'h00FF;
    wait_done(20, n);
    check_int("b2b_first_latency", n, 10);
    check16("b2b_first_result", Result, 16'hFF00);
    wait_done(20, n);
    check_int("b2b_second_latency", n, 12);
    check16("b2b_second_result", Result, 16'hFE01);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check16("b2b_result_held", Result, 16'hFE01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
